// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: register offsets, STATUS layout
// and the serializer state encoding.
package uart_pkg;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_BAUD   = 2'd2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_COUNT   = 8;
  localparam int STAT_COUNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } ser_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a push into a full FIFO is taken
// only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int Width = 8,
  parameter int Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         data_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int AW = $clog2(Depth);

  logic [Width-1:0] mem [Depth];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign count_o = wr_ptr - rd_ptr;
  assign full_o  = (count_o == (AW+1)'(Depth));
  assign empty_o = (wr_ptr == rd_ptr);
  assign data_o  = mem[rd_ptr[AW-1:0]];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/bus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus register decode with one-cycle
// grant, TX FIFO, and a bit-timed serializer.
//
// state | meaning
// IDLE  | line high, pops next byte when FIFO has data
// START | start bit (low) for one bit period
// DATA  | 8 data bits, LSB first
// STOP  | stop bit (high) for one bit period
module bus_uart_tx
  import uart_pkg::*;
#(
  parameter int          AddrWidth  = 32,
  parameter int          DataWidth  = 32,
  parameter int          FifoDepth  = 4,
  parameter logic [15:0] DefaultDiv = 16'd867
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 re_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [DataWidth-1:0] wdata_i,
  output logic [DataWidth-1:0] rdata_o,
  output logic                 gnt_o,
  output logic                 tx_o
);

  localparam int CntW = $clog2(FifoDepth) + 1;

  logic            fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [7:0]      fifo_head;
  logic [CntW-1:0] fifo_count;
  logic [15:0]     baud_div;
  logic [1:0]      reg_sel;
  logic            req, wr_stall, accept;
  logic [DataWidth-1:0] rd_val;

  ser_state_t  state, state_d;
  logic        tx_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_cnt, bit_cnt_d;
  logic [15:0] timer, timer_d;
  logic [15:0] div_lat, div_d;
  logic        bit_done;

  logic unused_bits;
  assign unused_bits = ^{addr_i[AddrWidth-1:4], addr_i[1:0], wdata_i[DataWidth-1:16]};

  assign reg_sel   = addr_i[3:2];
  assign req       = (re_i | we_i) & ~gnt_o;
  // A TXDATA write waits while full, but slips in on the cycle the serializer pops.
  assign wr_stall  = we_i & (reg_sel == REG_TXDATA) & fifo_full & ~fifo_pop;
  assign accept    = req & ~wr_stall;
  assign fifo_push = accept & we_i & (reg_sel == REG_TXDATA);

  sync_fifo #(
    .Width (8),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .data_i  (wdata_i[7:0]),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    rd_val = '0;
    case (reg_sel)
      REG_STATUS: begin
        rd_val[STAT_BUSY]  = (state != IDLE);
        rd_val[STAT_FULL]  = fifo_full;
        rd_val[STAT_EMPTY] = fifo_empty;
        rd_val[STAT_COUNT +: STAT_COUNT_W] = STAT_COUNT_W'(fifo_count);
      end
      REG_BAUD: rd_val[15:0] = baud_div;
      default:  rd_val = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      gnt_o    <= 1'b0;
      rdata_o  <= '0;
      baud_div <= DefaultDiv;
    end else begin
      gnt_o   <= accept;
      rdata_o <= (accept & ~we_i) ? rd_val : '0;
      if (accept & we_i & (reg_sel == REG_BAUD)) baud_div <= wdata_i[15:0];
    end
  end

  assign bit_done = (timer == 16'd0);

  always_comb begin
    state_d   = state;
    tx_d      = tx_o;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt;
    timer_d   = timer;
    div_d     = div_lat;
    fifo_pop  = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_head;
          div_d    = baud_div;
          timer_d  = baud_div;
          tx_d     = 1'b0;
          state_d  = START;
        end
      end
      START: begin
        if (bit_done) begin
          timer_d   = div_lat;
          tx_d      = shift_q[0];
          bit_cnt_d = 3'd0;
          state_d   = DATA;
        end else begin
          timer_d = timer - 16'd1;
        end
      end
      DATA: begin
        if (bit_done) begin
          timer_d = div_lat;
          if (bit_cnt == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
            bit_cnt_d = bit_cnt + 3'd1;
          end
        end else begin
          timer_d = timer - 16'd1;
        end
      end
      STOP: begin
        if (bit_done) state_d = IDLE;
        else          timer_d = timer - 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      tx_o    <= 1'b1;
      shift_q <= '0;
      bit_cnt <= '0;
      timer   <= '0;
      div_lat <= '0;
    end else begin
      state   <= state_d;
      tx_o    <= tx_d;
      shift_q <= shift_d;
      bit_cnt <= bit_cnt_d;
      timer   <= timer_d;
      div_lat <= div_d;
    end
  end

endmodule

// File: tb/tb_bus_uart_tx.sv
// Bench for bus_uart_tx: bus writes push expected bytes into a scoreboard,
// a line monitor decodes frames on tx_o and checks data and bit timing.
module tb_bus_uart_tx;
  import uart_pkg::*;

  localparam int          AW   = 32;
  localparam int          DW   = 32;
  localparam int          FD   = 4;
  localparam logic [15:0] DDIV = 16'd3;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          re_i  = 1'b0;
  logic          we_i  = 1'b0;
  logic [AW-1:0] addr_i  = '0;
  logic [DW-1:0] wdata_i = '0;
  logic [DW-1:0] rdata_o;
  logic          gnt_o;
  logic          tx_o;

  bus_uart_tx #(
    .AddrWidth  (AW),
    .DataWidth  (DW),
    .FifoDepth  (FD),
    .DefaultDiv (DDIV)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .re_i    (re_i),
    .we_i    (we_i),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .rdata_o (rdata_o),
    .gnt_o   (gnt_o),
    .tx_o    (tx_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [7:0] data;
    int         div;
  } exp_t;

  exp_t sb[$];
  int   n_tests  = 0;
  int   n_fail   = 0;
  int   cur_div  = 3;
  bit   mon_en   = 1'b1;
  bit   mon_busy = 1'b0;

  // Line monitor: every start bit consumes one scoreboard entry.
  initial begin : monitor
    logic       prev;
    logic [7:0] got;
    logic       lvl;
    bit         ok;
    bit         unexp;
    exp_t       e;
    int         p;
    prev = 1'b1;
    forever begin
      @(negedge clk_i);
      if (mon_en && rst_i && prev === 1'b1 && tx_o === 1'b0) begin
        mon_busy = 1'b1;
        ok = 1'b1;
        got = '0;
        unexp = 1'b0;
        if (sb.size() == 0) begin
          unexp  = 1'b1;
          e.data = '0;
          e.div  = cur_div;
        end else begin
          e = sb.pop_front();
        end
        p = e.div + 1;
        for (int b = 0; b < 10; b++) begin
          lvl = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : e.data[b-1];
          for (int j = 0; j < p; j++) begin
            if (tx_o !== lvl) ok = 1'b0;
            if (b >= 1 && b <= 8 && j == 0) got[b-1] = tx_o;
            if (!(b == 9 && j == p - 1)) @(negedge clk_i);
          end
        end
        n_tests++;
        if (unexp) begin
          n_fail++;
          $display("FAIL unexpected_frame: decoded byte %h, required no frame", got);
        end else if (!ok) begin
          n_fail++;
          $display("FAIL frame: got byte %h (level/timing ok=%0d), required %h at %0d clocks/bit",
                   got, ok, e.data, p);
        end
        mon_busy = 1'b0;
      end
      prev = tx_o;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic bus_write(input logic [1:0] sel, input logic [31:0] data, input bit both,
                           input bit track, output int lat, output logic tx_before,
                           output logic tx_at_gnt, output logic [DW-1:0] rd);
    @(negedge clk_i);
    if (gnt_o) @(negedge clk_i);
    addr_i = '0;
    addr_i[3:2] = sel;
    wdata_i = data;
    we_i = 1'b1;
    re_i = both;
    lat = 0;
    tx_before = tx_o;
    while (lat < 3000) begin
      tx_before = tx_o;
      @(posedge clk_i);
      #1;
      lat++;
      if (gnt_o) break;
    end
    tx_at_gnt = tx_o;
    rd = rdata_o;
    we_i = 1'b0;
    re_i = 1'b0;
    if (!gnt_o) begin
      n_tests++;
      n_fail++;
      $display("FAIL write_timeout: no gnt after %0d cycles, required a grant", lat);
    end else begin
      if (sel == REG_TXDATA && track) begin
        exp_t e;
        e.data = data[7:0];
        e.div  = cur_div;
        sb.push_back(e);
      end
      if (sel == REG_BAUD) cur_div = int'(data[15:0]);
    end
  endtask

  task automatic bus_read(input logic [1:0] sel, output logic [DW-1:0] rd, output int lat);
    @(negedge clk_i);
    if (gnt_o) @(negedge clk_i);
    addr_i = '0;
    addr_i[3:2] = sel;
    re_i = 1'b1;
    lat = 0;
    while (lat < 3000) begin
      @(posedge clk_i);
      #1;
      lat++;
      if (gnt_o) break;
    end
    rd = rdata_o;
    re_i = 1'b0;
    if (!gnt_o) begin
      n_tests++;
      n_fail++;
      $display("FAIL read_timeout: no gnt after %0d cycles, required a grant", lat);
    end
  endtask

  task automatic drain();
    int cyc = 0;
    while ((sb.size() != 0 || mon_busy) && cyc < 5000) begin
      @(posedge clk_i);
      cyc++;
    end
    n_tests++;
    if (cyc >= 5000) begin
      n_fail++;
      $display("FAIL drain: %0d bytes still pending after %0d cycles, required 0", sb.size(), cyc);
    end
    repeat (3) @(posedge clk_i);
  endtask

  task automatic test_reset();
    logic [DW-1:0] rd;
    int lat;
    repeat (2) @(negedge clk_i);
    n_tests++;
    if (tx_o !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b, required 1", tx_o); end
    n_tests++;
    if (gnt_o !== 1'b0) begin n_fail++; $display("FAIL reset_gnt: got %b, required 0", gnt_o); end
    n_tests++;
    if (rdata_o !== '0) begin n_fail++; $display("FAIL reset_rdata: got %h, required 0", rdata_o); end
    rst_i = 1'b1;
    bus_read(REG_STATUS, rd, lat);
    n_tests++;
    if (lat !== 1) begin n_fail++; $display("FAIL read_latency: got %0d, required 1", lat); end
    n_tests++;
    if (rd !== 32'h4) begin n_fail++; $display("FAIL reset_status: got %h, required 00000004", rd); end
    bus_read(REG_BAUD, rd, lat);
    n_tests++;
    if (rd !== 32'h3) begin n_fail++; $display("FAIL reset_baud: got %h, required 00000003", rd); end
  endtask

  task automatic test_single_frame();
    logic [DW-1:0] rd;
    logic tb_, ta_;
    int lat;
    bus_write(REG_TXDATA, 32'h55, 1'b0, 1'b1, lat, tb_, ta_, rd);
    n_tests++;
    if (lat !== 1) begin n_fail++; $display("FAIL write_latency: got %0d, required 1", lat); end
    repeat (4) @(posedge clk_i);
    bus_read(REG_STATUS, rd, lat);
    n_tests++;
    if (rd !== 32'h5) begin n_fail++; $display("FAIL status_busy: got %h, required 00000005", rd); end
    drain();
    bus_read(REG_STATUS, rd, lat);
    n_tests++;
    if (rd !== 32'h4) begin n_fail++; $display("FAIL status_idle: got %h, required 00000004", rd); end
  endtask

  task automatic test_baud_change();
    logic [DW-1:0] rd;
    logic tb_, ta_;
    int lat;
    bus_write(REG_TXDATA, 32'h3C, 1'b0, 1'b1, lat, tb_, ta_, rd);
    repeat (4) @(posedge clk_i);
    bus_write(REG_BAUD, 32'h1, 1'b0, 1'b0, lat, tb_, ta_, rd);
    bus_write(REG_TXDATA, 32'hA3, 1'b0, 1'b1, lat, tb_, ta_, rd);
    bus_read(REG_BAUD, rd, lat);
    n_tests++;
    if (rd !== 32'h1) begin n_fail++; $display("FAIL baud_readback: got %h, required 00000001", rd); end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] rd;
    logic tb_, ta_;
    int lat;
    logic [7:0] bytes [6];
    bytes = '{8'h11, 8'h22, 8'h84, 8'hF0, 8'h0F, 8'hC3};
    for (int i = 0; i < 5; i++) begin
      bus_write(REG_TXDATA, {24'd0, bytes[i]}, 1'b0, 1'b1, lat, tb_, ta_, rd);
      n_tests++;
      if (lat !== 1) begin n_fail++; $display("FAIL fill_latency[%0d]: got %0d, required 1", i, lat); end
    end
    bus_write(REG_TXDATA, {24'd0, bytes[5]}, 1'b0, 1'b1, lat, tb_, ta_, rd);
    n_tests++;
    if (lat < 5) begin n_fail++; $display("FAIL full_stall: got latency %0d, required >= 5", lat); end
    n_tests++;
    if (tb_ !== 1'b1 || ta_ !== 1'b0) begin
      n_fail++;
      $display("FAIL full_grant_align: tx before/at gnt got %b/%b, required 1/0", tb_, ta_);
    end
    drain();
  endtask

  task automatic test_rw_both();
    logic [DW-1:0] rd;
    logic tb_, ta_;
    int lat;
    bus_write(REG_TXDATA, 32'h7E, 1'b1, 1'b1, lat, tb_, ta_, rd);
    n_tests++;
    if (lat !== 1 || rd !== '0) begin
      n_fail++;
      $display("FAIL rw_both_grant: got lat %0d rdata %h, required 1/00000000", lat, rd);
    end
    @(posedge clk_i);
    #1;
    n_tests++;
    if (gnt_o !== 1'b0) begin n_fail++; $display("FAIL single_gnt: got %b, required 0", gnt_o); end
    drain();
  endtask

  task automatic test_reset_mid_frame();
    logic [DW-1:0] rd;
    logic tb_, ta_;
    int lat;
    bit stuck;
    mon_en = 1'b0;
    bus_write(REG_TXDATA, 32'h00, 1'b0, 1'b0, lat, tb_, ta_, rd);
    repeat (8) @(posedge clk_i);
    @(negedge clk_i);
    n_tests++;
    if (tx_o !== 1'b0) begin n_fail++; $display("FAIL mid_data_level: got %b, required 0", tx_o); end
    rst_i = 1'b0;
    #1;
    n_tests++;
    if (tx_o !== 1'b1 || gnt_o !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: tx/gnt got %b/%b, required 1/0", tx_o, gnt_o);
    end
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1;
    cur_div = 3;
    bus_read(REG_STATUS, rd, lat);
    n_tests++;
    if (rd !== 32'h4) begin n_fail++; $display("FAIL post_reset_status: got %h, required 00000004", rd); end
    bus_read(REG_BAUD, rd, lat);
    n_tests++;
    if (rd !== 32'h3) begin n_fail++; $display("FAIL post_reset_baud: got %h, required 00000003", rd); end
    stuck = 1'b0;
    repeat (40) begin
      @(negedge clk_i);
      if (tx_o !== 1'b1) stuck = 1'b1;
    end
    n_tests++;
    if (stuck) begin n_fail++; $display("FAIL no_resume: tx left idle after reset, required constant 1"); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_baud_change();
    test_back_to_back();
    test_rw_both();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
